// File: rtl/bist_tpg_gen_if.sv
// Stream and control bundle between a BIST controller and the test-pattern generator.
interface bist_tpg_gen_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             start;
  logic             abort;
  logic [1:0]       mode;
  logic [CNT_W-1:0] pattern_count;
  logic             seed_load;
  logic [WIDTH-1:0] seed_in;
  logic             tpg_ready;
  logic [WIDTH-1:0] tpg_out;
  logic             tpg_valid;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, mode, pattern_count, seed_load, seed_in, tpg_ready,
    input  tpg_out, tpg_valid, busy, done
  );

  modport slave (
    input  start, abort, mode, pattern_count, seed_load, seed_in, tpg_ready,
    output tpg_out, tpg_valid, busy, done
  );
endinterface

// File: rtl/bist_tpg_gen.sv
// Multi-mode BIST pattern source: LFSR, walking-one, binary count and checkerboard
// patterns streamed over valid/ready, with run control and a loadable seed.
module bist_tpg_gen #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(8'hB8),
  parameter logic [WIDTH-1:0] SEED  = '1,
  parameter int               CNT_W = 16
) (
  input  logic          clk,
  input  logic          reset,
  bist_tpg_gen_if.slave tif
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [1:0] M_LFSR = 2'b00;
  localparam logic [1:0] M_WALK = 2'b01;
  localparam logic [1:0] M_CNT  = 2'b10;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_seed, r_q;
  logic [1:0]       r_mode;
  logic [CNT_W-1:0] r_remaining;
  logic [WIDTH-1:0] w_lfsr, w_q_adv, w_q_init;
  logic             w_accept, w_last;

  assign w_accept = (r_state == S_RUN) & tif.tpg_ready;
  assign w_last   = (r_remaining == CNT_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // abort outranks an accept landing in the same cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (tif.start) w_state_nxt = (tif.pattern_count == '0) ? S_DONE : S_RUN;
      S_RUN: begin
        if (tif.abort)             w_state_nxt = S_IDLE;
        else if (w_accept && w_last) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // next pattern; an all-zero LFSR result (only possible with non-maximal taps) reseeds
  always_comb begin
    w_lfsr  = {r_q[WIDTH-2:0], ^(r_q & TAPS)};
    w_q_adv = ~r_q;
    case (r_mode)
      M_LFSR:  w_q_adv = (w_lfsr == '0) ? r_seed : w_lfsr;
      M_WALK:  w_q_adv = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
      M_CNT:   w_q_adv = r_q + WIDTH'(1);
      default: w_q_adv = ~r_q;
    endcase
  end

  always_comb begin
    w_q_init = {(WIDTH/2){2'b01}};
    case (tif.mode)
      M_LFSR:  w_q_init = r_seed;
      M_WALK:  w_q_init = WIDTH'(1);
      M_CNT:   w_q_init = '0;
      default: w_q_init = {(WIDTH/2){2'b01}};
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seed      <= SEED;
      r_q         <= SEED;
      r_mode      <= M_LFSR;
      r_remaining <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (tif.start) begin
            r_mode      <= tif.mode;
            r_remaining <= tif.pattern_count;
            r_q         <= w_q_init;
          end else if (tif.seed_load) begin
            r_seed <= (tif.seed_in == '0) ? SEED : tif.seed_in;
          end
        end
        S_RUN: begin
          if (!tif.abort && w_accept) begin
            r_q         <= w_q_adv;
            r_remaining <= r_remaining - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign tif.tpg_out   = r_q;
  assign tif.tpg_valid = (r_state == S_RUN);
  assign tif.busy      = (r_state == S_RUN);
  assign tif.done      = (r_state == S_DONE);
endmodule
